// File: rtl/anti_theft_pkg.sv
// Shared encodings for the car anti-theft controller.
// State codes are visible on the debug/display state output.
package anti_theft_pkg;

    typedef enum logic [2:0] {
        ARMED           = 3'd0,
        ENTRY_WAIT      = 3'd1,
        ALARM           = 3'd2,
        ALARM_HOLD      = 3'd3,
        DISARMED        = 3'd4,
        WAIT_DOOR_OPEN  = 3'd5,
        WAIT_DOOR_CLOSE = 3'd6,
        ARM_DELAY       = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        TSEL_ARM       = 2'd0,
        TSEL_DRIVER    = 2'd1,
        TSEL_PASSENGER = 2'd2,
        TSEL_ALARM     = 2'd3
    } tsel_e;

endpackage

// File: rtl/sec_countdown.sv
// Seconds countdown with load and a one-cycle expiry pulse.
// A load takes priority over the 1 Hz decrement in the same cycle.
module sec_countdown #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         one_hz_enable,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] count,
    output logic         expired
);

    logic [W-1:0] count_q;
    logic         active_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q  <= '0;
            active_q <= 1'b0;
        end else if (load) begin
            count_q  <= load_value;
            active_q <= 1'b1;
        end else begin
            if (expired) begin
                active_q <= 1'b0;
            end
            if (one_hz_enable && count_q != '0) begin
                count_q <= count_q - W'(1);
            end
        end
    end

    // Only fires once per load: active drops on the expiry cycle.
    assign expired = active_q && (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/anti_theft_fsm.sv
// Car anti-theft controller: doors, entry/exit delays, siren, LED, fuel pump.
// Define ANTI_THEFT_ARMED_BLINK_EN to blink the status LED while ARMED.
module anti_theft_fsm
    import anti_theft_pkg::*;
#(
    parameter int N_DOORS           = 2,
    parameter int TIME_W            = 4,
    parameter int T_ARM_DELAY       = 6,
    parameter int T_DRIVER_DELAY    = 8,
    parameter int T_PASSENGER_DELAY = 15,
    parameter int T_ALARM_ON        = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               one_hz_enable,
    input  logic [N_DOORS-1:0] door,
    input  logic               ignition,
    input  logic               hidden,
    input  logic               brake,
    output logic [2:0]         state,
    output logic               siren,
    output logic               status_led,
    output logic               fuel_pump,
    output logic [TIME_W-1:0]  time_left
);

    localparam int T_MAX = (1 << TIME_W) - 1;

    if (T_ARM_DELAY > T_MAX || T_DRIVER_DELAY > T_MAX ||
        T_PASSENGER_DELAY > T_MAX || T_ALARM_ON > T_MAX) begin : g_bad_delay
        $error("anti_theft_fsm: delay parameter exceeds TIME_W range");
    end

    if (N_DOORS < 1) begin : g_bad_doors
        $error("anti_theft_fsm: N_DOORS must be at least 1");
    end

    state_e              state_q, state_d;
    logic                siren_q, led_q, led_d, fuel_q;
    logic                load, expired;
    tsel_e               tsel;
    logic [TIME_W-1:0]   load_value, count;
    logic                any_open;

    assign any_open = |door;

    sec_countdown #(
        .W (TIME_W)
    ) u_timer (
        .clock         (clock),
        .reset         (reset),
        .one_hz_enable (one_hz_enable),
        .load          (load),
        .load_value    (load_value),
        .count         (count),
        .expired       (expired)
    );

    always_comb begin
        unique case (tsel)
            TSEL_ARM:       load_value = TIME_W'(T_ARM_DELAY);
            TSEL_DRIVER:    load_value = TIME_W'(T_DRIVER_DELAY);
            TSEL_PASSENGER: load_value = TIME_W'(T_PASSENGER_DELAY);
            TSEL_ALARM:     load_value = TIME_W'(T_ALARM_ON);
            default:        load_value = '0;
        endcase
    end

    // Ignition beats door events, which beat timer expiry.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        tsel    = TSEL_ARM;
        if (ignition) begin
            state_d = DISARMED;
        end else begin
            case (state_q)
                ARMED: if (any_open) begin
                    state_d = ENTRY_WAIT;
                    load    = 1'b1;
                    tsel    = door[0] ? TSEL_DRIVER : TSEL_PASSENGER;
                end
                ENTRY_WAIT: if (expired) state_d = ALARM;
                ALARM: if (!any_open) begin
                    state_d = ALARM_HOLD;
                    load    = 1'b1;
                    tsel    = TSEL_ALARM;
                end
                ALARM_HOLD: begin
                    if (any_open)     state_d = ALARM;
                    else if (expired) state_d = ARMED;
                end
                DISARMED: state_d = WAIT_DOOR_OPEN;
                WAIT_DOOR_OPEN: if (door[0]) state_d = WAIT_DOOR_CLOSE;
                WAIT_DOOR_CLOSE: if (!any_open) begin
                    state_d = ARM_DELAY;
                    load    = 1'b1;
                    tsel    = TSEL_ARM;
                end
                ARM_DELAY: begin
                    if (any_open)     state_d = WAIT_DOOR_CLOSE;
                    else if (expired) state_d = ARMED;
                end
                default: state_d = ARMED;
            endcase
        end
    end

    always_comb begin
        led_d = (state_d == ENTRY_WAIT) || (state_d == ALARM) ||
                (state_d == ALARM_HOLD);
`ifdef ANTI_THEFT_ARMED_BLINK_EN
        if (state_d == ARMED && state_q == ARMED) begin
            led_d = led_q ^ one_hz_enable;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ARMED;
            siren_q <= 1'b0;
            led_q   <= 1'b0;
            fuel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            siren_q <= (state_d == ALARM) || (state_d == ALARM_HOLD);
            led_q   <= led_d;
            fuel_q  <= ignition && (fuel_q || (hidden && brake));
        end
    end

    assign state      = state_q;
    assign siren      = siren_q;
    assign status_led = led_q;
    assign fuel_pump  = fuel_q;
    assign time_left  = count;

endmodule

// File: tb/tb_anti_theft_fsm.sv
// Directed bench for anti_theft_fsm; vector = {state,siren,led,fuel,time_left}.
module tb_anti_theft_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       one_hz = 1'b0;
    logic [1:0] door = 2'b00;
    logic       ignition = 1'b0;
    logic       hidden = 1'b0;
    logic       brake = 1'b0;
    logic [2:0] state;
    logic       siren, status_led, fuel_pump;
    logic [3:0] time_left;

    logic [9:0] obs;
    logic [9:0] exp_v;
    int checks = 0;
    int errors = 0;

    assign obs = {state, siren, status_led, fuel_pump, time_left};

    anti_theft_fsm dut (
        .clock         (clk),
        .reset         (reset),
        .one_hz_enable (one_hz),
        .door          (door),
        .ignition      (ignition),
        .hidden        (hidden),
        .brake         (brake),
        .state         (state),
        .siren         (siren),
        .status_led    (status_led),
        .fuel_pump     (fuel_pump),
        .time_left     (time_left)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            one_hz = 1'b1;
            tick();
            one_hz = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_v = {3'd0, 1'b0, 1'b0, 1'b0, 4'd0};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_state got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_passenger_alarm();
        door = 2'b10;
        tick();
        exp_v = {3'd1, 1'b0, 1'b1, 1'b0, 4'd15};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL pass_entry got %h want %h", obs, exp_v);
        end
        pulse(14);
        exp_v = {3'd1, 1'b0, 1'b1, 1'b0, 4'd1};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL pass_14 got %h want %h", obs, exp_v);
        end
        pulse(1);
        exp_v = {3'd1, 1'b0, 1'b1, 1'b0, 4'd0};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL pass_zero got %h want %h", obs, exp_v);
        end
        tick();
        exp_v = {3'd2, 1'b1, 1'b1, 1'b0, 4'd0};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL pass_alarm got %h want %h", obs, exp_v);
        end
        tick();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL alarm_stays got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_alarm_hold();
        door = 2'b00;
        tick();
        exp_v = {3'd3, 1'b1, 1'b1, 1'b0, 4'd10};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL hold_entry got %h want %h", obs, exp_v);
        end
        pulse(4);
        door = 2'b10;
        tick();
        exp_v = {3'd2, 1'b1, 1'b1, 1'b0, 4'd6};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL hold_reopen got %h want %h", obs, exp_v);
        end
        door = 2'b00;
        tick();
        exp_v = {3'd3, 1'b1, 1'b1, 1'b0, 4'd10};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL hold_reload got %h want %h", obs, exp_v);
        end
        pulse(10);
        exp_v = {3'd3, 1'b1, 1'b1, 1'b0, 4'd0};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL hold_zero got %h want %h", obs, exp_v);
        end
        tick();
        exp_v = {3'd0, 1'b0, 1'b0, 1'b0, 4'd0};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL hold_armed got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_driver_priority();
        door = 2'b11;
        tick();
        door = 2'b00;
        exp_v = {3'd1, 1'b0, 1'b1, 1'b0, 4'd8};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL drv_entry got %h want %h", obs, exp_v);
        end
        pulse(4);
        exp_v = {3'd1, 1'b0, 1'b1, 1'b0, 4'd4};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL drv_closed_runs got %h want %h", obs, exp_v);
        end
        ignition = 1'b1;
        pulse(1);
        exp_v = {3'd4, 1'b0, 1'b0, 1'b0, 4'd3};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL drv_disarm got %h want %h", obs, exp_v);
        end
        pulse(3);
        tick();
        exp_v = {3'd4, 1'b0, 1'b0, 1'b0, 4'd0};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL drv_no_alarm got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_arm_delay();
        ignition = 1'b0;
        tick();
        exp_v = {3'd5, 1'b0, 1'b0, 1'b0, 4'd0};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL arm_wait_open got %h want %h", obs, exp_v);
        end
        door = 2'b10;
        tick();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL arm_pass_ignored got %h want %h", obs, exp_v);
        end
        door = 2'b01;
        tick();
        exp_v = {3'd6, 1'b0, 1'b0, 1'b0, 4'd0};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL arm_wait_close got %h want %h", obs, exp_v);
        end
        door = 2'b00;
        tick();
        exp_v = {3'd7, 1'b0, 1'b0, 1'b0, 4'd6};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL arm_delay got %h want %h", obs, exp_v);
        end
        pulse(3);
        door = 2'b01;
        tick();
        exp_v = {3'd6, 1'b0, 1'b0, 1'b0, 4'd3};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL arm_reopen got %h want %h", obs, exp_v);
        end
        door = 2'b00;
        tick();
        exp_v = {3'd7, 1'b0, 1'b0, 1'b0, 4'd6};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL arm_restart got %h want %h", obs, exp_v);
        end
        pulse(6);
        exp_v = {3'd7, 1'b0, 1'b0, 1'b0, 4'd0};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL arm_zero got %h want %h", obs, exp_v);
        end
        tick();
        exp_v = {3'd0, 1'b0, 1'b0, 1'b0, 4'd0};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL arm_armed got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_fuel_pump();
        ignition = 1'b1;
        hidden   = 1'b1;
        brake    = 1'b0;
        tick();
        exp_v = {3'd4, 1'b0, 1'b0, 1'b0, 4'd0};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL fuel_no_brake got %h want %h", obs, exp_v);
        end
        brake = 1'b1;
        tick();
        hidden = 1'b0;
        brake  = 1'b0;
        exp_v = {3'd4, 1'b0, 1'b0, 1'b1, 4'd0};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL fuel_set got %h want %h", obs, exp_v);
        end
        tick();
        tick();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL fuel_hold got %h want %h", obs, exp_v);
        end
        ignition = 1'b0;
        tick();
        exp_v = {3'd5, 1'b0, 1'b0, 1'b0, 4'd0};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL fuel_clear got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_reset_mid_countdown();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        door = 2'b01;
        tick();
        door = 2'b00;
        pulse(5);
        exp_v = {3'd1, 1'b0, 1'b1, 1'b0, 4'd3};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL rst_pre got %h want %h", obs, exp_v);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_v = {3'd0, 1'b0, 1'b0, 1'b0, 4'd0};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL rst_abort got %h want %h", obs, exp_v);
        end
        tick();
        tick();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL rst_no_expiry got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_armed_led();
        logic [2:0] led_seq;
`ifdef ANTI_THEFT_ARMED_BLINK_EN
        led_seq = 3'b101;
`else
        led_seq = 3'b000;
`endif
        for (int i = 0; i < 3; i++) begin
            pulse(1);
            exp_v = {3'd0, 1'b0, led_seq[i], 1'b0, 4'd0};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL armed_led_%0d got %h want %h", i, obs, exp_v);
            end
        end
        tick();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL armed_led_idle got %h want %h", obs, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_passenger_alarm();
        test_alarm_hold();
        test_driver_priority();
        test_arm_delay();
        test_fuel_pump();
        test_reset_mid_countdown();
        test_armed_led();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/anti_theft_fsm.md
Name: anti_theft_fsm

Overview:
Parametrised car anti-theft controller for the Lab 4 alarm system. It has N_DOORS door sensors, an integrated seconds countdown timer and separate entry/exit delays. It drives the siren, the status LED and the fuel-pump enable. It sits between the debounced/synchronised switch inputs and the siren/LED drivers, and takes a 1 Hz enable pulse from the shared divider.

Parameters:
N_DOORS, 2, number of door sensors; bit 0 is the driver door, all others are passenger doors
TIME_W, 4, width of the seconds counter and of the time_left output
T_ARM_DELAY, 6, seconds from driver door closing (ignition off) until ARMED
T_DRIVER_DELAY, 8, entry grace in seconds when the driver door opens first
T_PASSENGER_DELAY, 15, entry grace in seconds when only a passenger door opens
T_ALARM_ON, 10, seconds the siren keeps sounding after all doors close

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high
one_hz_enable  input  1  single-cycle pulse once per second
door  input  N_DOORS  1 = door open; bit 0 = driver
ignition  input  1  1 = key on
hidden  input  1  hidden switch, 1 = pressed
brake  input  1  brake pedal, 1 = pressed
state  output  3  current state encoding (debug/display)
siren  output  1  1 = siren on
status_led  output  1  armed/alarm indicator
fuel_pump  output  1  1 = fuel pump powered
time_left  output  TIME_W  current countdown value (for display)

Behaviour:
- States and encodings: ARMED=0, ENTRY_WAIT=1, ALARM=2, ALARM_HOLD=3, DISARMED=4, WAIT_DOOR_OPEN=5, WAIT_DOOR_CLOSE=6, ARM_DELAY=7.
- Reset: state=ARMED, siren=0, status_led=0, fuel_pump=0, time_left=0. Reset in any state aborts the countdown.
- Priority order, highest first: reset, then ignition=1, then door events, then timer expiry.
- Rule A: ignition=1 in any state -> DISARMED next cycle.
- ARMED, any door open -> ENTRY_WAIT. Load T_DRIVER_DELAY if door[0]=1, otherwise T_PASSENGER_DELAY. If driver and passenger doors open in the same cycle, the driver delay wins.
- ENTRY_WAIT, expiry -> ALARM. Doors closing during ENTRY_WAIT do not stop the countdown.
- ALARM: siren=1. All doors closed -> ALARM_HOLD, load T_ALARM_ON.
- ALARM_HOLD: siren=1. Any door reopens -> ALARM. Expiry -> ARMED.
- DISARMED, ignition=0 -> WAIT_DOOR_OPEN.
- WAIT_DOOR_OPEN, door[0]=1 -> WAIT_DOOR_CLOSE.
- WAIT_DOOR_CLOSE, all doors closed -> ARM_DELAY, load T_ARM_DELAY.
- ARM_DELAY: any door opens -> WAIT_DOOR_CLOSE; the delay restarts on the next close. Expiry -> ARMED.
- Timer:
  - Load takes effect in the same clock edge as the state transition.
  - Decrements by 1 only on cycles where one_hz_enable=1 and count>0.
  - expired is a one-cycle internal pulse, asserted on the cycle after count reaches 0 while a countdown is active.
  - A load value of 0 expires on the next cycle.
  - A load in the same cycle as one_hz_enable=1 takes the loaded value (no decrement that cycle).
  - time_left mirrors count.
- Output timing: all outputs are registered from the state/count registers (one cycle after the input change). siren=1 only in ALARM and ALARM_HOLD.
- status_led: 1 in ENTRY_WAIT, ALARM and ALARM_HOLD; 0 otherwise, except as modified by the optional feature.
- fuel_pump:
  - Set when ignition=1 and hidden=1 and brake=1 in the same cycle.
  - Held while ignition=1.
  - Cleared on the cycle after ignition=0, and on reset.
- Width rule: delay parameters above 2^TIME_W-1 are a configuration error and must be flagged by an elaboration-time check.

Optional Feature:
- Macro: ANTI_THEFT_ARMED_BLINK_EN.
- Defined: in ARMED, status_led toggles on every one_hz_enable (2 s period), starting at 0 on entry to ARMED.
- Not defined: status_led=0 in ARMED. All other states are unaffected either way.

Decomposition:
- Shared package anti_theft_pkg holds:
  - state encoding constants
  - the timer-select constants TSEL_ARM, TSEL_DRIVER, TSEL_PASSENGER, TSEL_ALARM
- One sub-module, sec_countdown, with ports clock, reset, one_hz_enable, load, load_value, count, expired.
- The FSM selects load_value through a parameter mux.

Test Plan:
- Reset, ARMED, door=2'b10, no ignition -> ENTRY_WAIT with time_left=15; after 15 one_hz_enable pulses, expired; next cycle state=ALARM, siren=1.
- ARMED, door=2'b11 in the same cycle -> time_left=8 (driver priority); ignition=1 at pulse 5 -> DISARMED, siren stays 0.
- ALARM, close all doors -> ALARM_HOLD, time_left=10; reopen door[1] at pulse 4 -> ALARM; close again -> reload to 10; after 10 pulses -> ARMED, siren=0.
- DISARMED, ignition=0, door[0] open then closed -> ARM_DELAY, time_left=6; reopen at pulse 3 -> WAIT_DOOR_CLOSE; close, then 6 pulses -> ARMED.
- ignition=1, hidden=1, brake=1 for one cycle -> fuel_pump=1 and stays high with hidden=0; ignition=0 -> fuel_pump=0 next cycle.
- reset asserted mid-ENTRY_WAIT (time_left=3) -> next cycle state=ARMED, time_left=0, siren=0. Repeat with ANTI_THEFT_ARMED_BLINK_EN defined: check the LED toggles each pulse in ARMED.
